// File: rtl/ghostbus_pkg.sv
// ============================================================================
// Module      : ghostbus_pkg
// Description : Shared types and constants for the ghostbus host sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ghostbus_pkg;

    localparam int c_DEF_AW     = 24;
    localparam int c_DEF_DW     = 32;
    localparam int c_RD_LAT_MAX = 15;
    localparam int c_LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        GB_IDLE   = 2'd0,
        GB_STROBE = 2'd1,
        GB_WAIT   = 2'd2,
        GB_RESP   = 2'd3
    } gb_host_state_t;

    // Counter preload for a read: zero means "capture in the strobe cycle".
    function automatic logic [c_LAT_CNT_W-1:0] lat_load(input int rd_lat);
        return c_LAT_CNT_W'(rd_lat - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ghostbus_host_seq.sv
// ============================================================================
// Module      : ghostbus_host_seq
// Description : Ghostbus initiator; single-beat commands in, one strobe per
//               command, read data returned on a response port.
//               Optional macro GHOSTBUS_HOST_WRITE_ACK_EN adds write responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghostbus_host_seq
    import ghostbus_pkg::*;
#(
    parameter int AW     = c_DEF_AW,
    parameter int DW     = c_DEF_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_rdata,
    output logic          busy
);

    gb_host_state_t         state_q;
    logic [c_LAT_CNT_W-1:0] cnt_q;
    logic                   op_we_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_we_q;
    logic [DW-1:0]          rsp_rdata_q;
    logic [AW-1:0]          gb_addr_q;
    logic [DW-1:0]          gb_wdata_q;
    logic                   gb_we_q;
    logic                   gb_re_q;
    logic                   busy_q;

    // The latency counter is loaded on accept so the strobe cycle counts as
    // the first read-latency cycle; capture happens when it reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GB_IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            gb_addr_q   <= '0;
            gb_wdata_q  <= '0;
            gb_we_q     <= 1'b0;
            gb_re_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            gb_we_q <= 1'b0;
            gb_re_q <= 1'b0;
            case (state_q)
                GB_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        gb_addr_q   <= cmd_addr;
                        gb_wdata_q  <= cmd_wdata;
                        op_we_q     <= cmd_we;
                        gb_we_q     <= cmd_we;
                        gb_re_q     <= !cmd_we;
                        cnt_q       <= lat_load(RD_LAT);
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= GB_STROBE;
                    end
                end
                GB_STROBE, GB_WAIT: begin
                    if (op_we_q) begin
`ifdef GHOSTBUS_HOST_WRITE_ACK_EN
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= GB_RESP;
`else
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= GB_IDLE;
`endif
                    end else if (cnt_q == '0) begin
                        rsp_rdata_q <= gb_rdata;
                        rsp_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= GB_RESP;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= GB_WAIT;
                    end
                end
                GB_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= GB_IDLE;
                    end
                end
                default: begin
                    state_q <= GB_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign gb_addr   = gb_addr_q;
    assign gb_wdata  = gb_wdata_q;
    assign gb_we     = gb_we_q;
    assign gb_re     = gb_re_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ghostbus_host_seq.sv
// ============================================================================
// Module      : tb_ghostbus_host_seq
// Description : Directed self-checking bench for ghostbus_host_seq, with one
//               instance at RD_LAT=1 and one at RD_LAT=4.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ghostbus_host_seq;

    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_ready;

    logic          cmd_valid1, cmd_ready1, rsp_valid1, rsp_we1, gb_we1, gb_re1, busy1;
    logic [DW-1:0] rsp_rdata1, gb_wdata1, gb_rdata1;
    logic [AW-1:0] gb_addr1;

    logic          cmd_valid4, cmd_ready4, rsp_valid4, rsp_we4, gb_we4, gb_re4, busy4;
    logic [DW-1:0] rsp_rdata4, gb_wdata4, gb_rdata4;
    logic [AW-1:0] gb_addr4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ghostbus_host_seq #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_we(rsp_we1),
        .rsp_rdata(rsp_rdata1),
        .gb_addr(gb_addr1), .gb_wdata(gb_wdata1), .gb_we(gb_we1), .gb_re(gb_re1),
        .gb_rdata(gb_rdata1), .busy(busy1)
    );

    ghostbus_host_seq #(.AW(AW), .DW(DW), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_we(rsp_we4),
        .rsp_rdata(rsp_rdata4),
        .gb_addr(gb_addr4), .gb_wdata(gb_wdata4), .gb_we(gb_we4), .gb_re(gb_re4),
        .gb_rdata(gb_rdata4), .busy(busy4)
    );

    // Bus models: good data only in the cycle the read latency points at.
    assign gb_rdata1 = gb_re1 ? 32'h0000_00A5 : 32'hBAD1_BAD1;

    logic [3:0] age4;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          age4 <= 4'd0;
        else if (gb_re4)                     age4 <= 4'd2;
        else if (age4 != 4'd0 && age4 != 4'd15) age4 <= age4 + 4'd1;
    end
    assign gb_rdata4 = (age4 == 4'd4 && !gb_re4) ? 32'h1234_5678 : {28'hDEAD_BEE, age4};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; cmd_valid1 = 1'b0; cmd_valid4 = 1'b0; cmd_we = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;

        // Reset values
        tick; tick;
        check_eq("rst_ctl1", 64'({cmd_ready1, rsp_valid1, rsp_we1, gb_we1, gb_re1, busy1}), 64'h0);
        check_eq("rst_addr1", 64'(gb_addr1), 64'h0);
        check_eq("rst_data1", 64'({gb_wdata1, rsp_rdata1}), 64'h0);
        check_eq("rst_ctl4", 64'({cmd_ready4, rsp_valid4, rsp_we4, gb_we4, gb_re4, busy4}), 64'h0);
        rst_n = 1'b1;
        tick;
        check_eq("rdy_after_rst", 64'({cmd_ready1, cmd_ready4, busy1}), 64'b110);

        // Single write 0x40 <= 0x42
        cmd_valid1 = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h40; cmd_wdata = 32'h42;
        tick;
        cmd_valid1 = 1'b0;
        check_eq("wr_strobe", 64'({gb_we1, gb_re1, cmd_ready1, busy1}), 64'b1001);
        check_eq("wr_addr", 64'(gb_addr1), 64'h40);
        check_eq("wr_wdata", 64'(gb_wdata1), 64'h42);
        tick;
`ifdef GHOSTBUS_HOST_WRITE_ACK_EN
        check_eq("wr_ack", 64'({gb_we1, rsp_valid1, rsp_we1, cmd_ready1}), 64'b0110);
        tick;
        check_eq("wr_ack_done", 64'({rsp_valid1, cmd_ready1}), 64'b01);
`else
        check_eq("wr_done", 64'({gb_we1, rsp_valid1, cmd_ready1, busy1}), 64'b0010);
`endif

        // Read at RD_LAT=1; write data bus follows the read accept too
        cmd_valid1 = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h40; cmd_wdata = 32'h77;
        tick;
        cmd_valid1 = 1'b0;
        check_eq("rd1_strobe", 64'({gb_we1, gb_re1, rsp_valid1}), 64'b010);
        check_eq("rd1_wdata", 64'(gb_wdata1), 64'h77);
        tick;
        check_eq("rd1_rsp", 64'({gb_re1, rsp_valid1, rsp_we1}), 64'b010);
        check_eq("rd1_rdata", 64'(rsp_rdata1), 64'hA5);
        tick;
        check_eq("rd1_idle", 64'({rsp_valid1, cmd_ready1}), 64'b01);

        // Back-to-back writes 0x01, 0x02
        cmd_valid1 = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h10; cmd_wdata = 32'h01;
        for (int w = 1; w <= 2; w++) begin
            tick;
            check_eq("b2b_strobe", 64'({gb_we1, gb_wdata1}), {31'h0, 1'b1, 32'(w)});
            cmd_wdata = 32'h02;
            if (w == 2) cmd_valid1 = 1'b0;
`ifdef GHOSTBUS_HOST_WRITE_ACK_EN
            tick;
            check_eq("b2b_rsp", 64'({rsp_valid1, rsp_we1, cmd_ready1}), 64'b110);
            check_eq("b2b_rdata", 64'(rsp_rdata1), 64'h0);
            tick;
            check_eq("b2b_drain", 64'({rsp_valid1, cmd_ready1}), 64'b01);
`else
            tick;
            check_eq("b2b_rdy", 64'({rsp_valid1, cmd_ready1, gb_we1}), 64'b010);
`endif
        end

        // RD_LAT=4 read with response back-pressure
        rsp_ready = 1'b0; cmd_valid4 = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h80; cmd_wdata = 32'h0;
        tick;
        check_eq("rd4_strobe", 64'({gb_re4, gb_we4, cmd_ready4}), 64'b100);
        for (int i = 2; i <= 4; i++) begin
            tick;
            check_eq("rd4_wait", 64'({rsp_valid4, gb_re4, gb_we4, cmd_ready4}), 64'h0);
        end
        tick;
        check_eq("rd4_rsp", 64'({rsp_valid4, rsp_we4}), 64'b10);
        check_eq("rd4_rdata", 64'(rsp_rdata4), 64'h1234_5678);
        for (int i = 0; i < 10; i++) begin
            tick;
            check_eq("rd4_hold", 64'({rsp_valid4, cmd_ready4, gb_re4, gb_we4, busy4}), 64'b10001);
            check_eq("rd4_hold_data", 64'(rsp_rdata4), 64'h1234_5678);
        end
        // Command still offered while the response drains: accepted only from IDLE
        rsp_ready = 1'b1; cmd_addr = 24'h84;
        tick;
        check_eq("rd4_drain", 64'({rsp_valid4, cmd_ready4, gb_re4}), 64'b010);
        tick;
        cmd_valid4 = 1'b0;
        check_eq("rd4_next_strobe", 64'({gb_re4, cmd_ready4}), 64'b10);
        check_eq("rd4_next_addr", 64'(gb_addr4), 64'h84);
        for (int i = 2; i <= 4; i++) begin
            tick;
            check_eq("rd4_next_wait", 64'(rsp_valid4), 64'h0);
        end
        tick;
        check_eq("rd4_next_rsp", 64'({rsp_valid4, rsp_rdata4}), {31'h0, 1'b1, 32'h1234_5678});
        tick;
        check_eq("rd4_next_idle", 64'({rsp_valid4, cmd_ready4}), 64'b01);

        // Reset during WAIT aborts the read
        cmd_valid4 = 1'b1; cmd_addr = 24'h88;
        tick;
        cmd_valid4 = 1'b0;
        tick;
        check_eq("abort_in_wait", 64'({busy4, gb_re4, rsp_valid4}), 64'b100);
        rst_n = 1'b0;
        #1;
        check_eq("abort_outs", 64'({gb_re4, gb_we4, rsp_valid4, busy4, cmd_ready4}), 64'h0);
        check_eq("abort_addr", 64'(gb_addr4), 64'h0);
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rsp_valid4 || gb_re4) seen++;
        end
        check_eq("abort_no_rsp", 64'(seen), 64'h0);
        check_eq("abort_rdy", 64'({cmd_ready4, busy4}), 64'b10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
